sprite_mover: RTL and testbench

SPRITE_MOVER -- requirements
Module: sprite_mover

---
 rtl/sprite_mover.sv | 183 ++++++++++++++++++
 tb/tb_sprite_mover.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mover.sv
// Sprite position/heading controller for a maze game: draws a square sprite box,
// senses maze walls on four probe strips around it and steps one pixel per movement tick.
module sprite_mover #(
    parameter int CW          = 10,
    parameter int SIZE        = 17,
    parameter int STEP_PERIOD = 10000,
    parameter int X_INI       = 190,
    parameter int Y_INI       = 318,
    parameter int X_MIN       = 8,
    parameter int X_MAX       = 380,
    parameter int Y_MIN       = 8,
    parameter int Y_MAX       = 432,
    parameter int H_OFF       = 274,
    parameter int V_OFF       = 58
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic          enable,
    input  logic [3:0]    dir_req,
    input  logic [CW-1:0] hcount,
    input  logic [CW-1:0] vcount,
    input  logic          frame_start,
    input  logic          wall_px,
    output logic          sprite_fill,
    output logic [CW-1:0] pos_x,
    output logic [CW-1:0] pos_y,
    output logic [3:0]    heading,
    output logic [3:0]    blocked,
    output logic          step_strobe
);

    localparam int H  = (SIZE - 1) / 2;
    localparam int EW = CW + 3;
    localparam int TW = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;

    typedef logic signed [EW-1:0] coord_t;

    localparam coord_t C_H    = coord_t'(H);
    localparam coord_t C_PRB  = coord_t'(H + 2);
    localparam coord_t C_HOFF = coord_t'(H_OFF);
    localparam coord_t C_VOFF = coord_t'(V_OFF);
    localparam coord_t C_ONE  = coord_t'(1);
    localparam coord_t C_XMIN = coord_t'(X_MIN);
    localparam coord_t C_XMAX = coord_t'(X_MAX);
    localparam coord_t C_YMIN = coord_t'(Y_MIN);
    localparam coord_t C_YMAX = coord_t'(Y_MAX);
    localparam logic [TW-1:0] C_CNT_LAST = TW'(STEP_PERIOD - 1);

    // Direction bit positions within {L,U,R,D}
    localparam int B_L = 3;
    localparam int B_U = 2;
    localparam int B_R = 1;
    localparam int B_D = 0;

    logic [CW-1:0] r_pos_x;
    logic [CW-1:0] r_pos_y;
    logic [3:0]    r_heading;
    logic [3:0]    r_pending;
    logic [3:0]    r_blocked;
    logic [3:0]    r_acc;
    logic [TW-1:0] r_cnt;
    logic          r_strobe;

    coord_t        w_cx;
    coord_t        w_cy;
    coord_t        w_hc;
    coord_t        w_vc;
    coord_t        w_nx;
    coord_t        w_ny;
    logic          w_in_h;
    logic          w_in_v;
    logic [3:0]    w_probe;
    logic [3:0]    w_hit;
    logic [3:0]    w_acc_next;
    logic          w_tick;
    logic [TW-1:0] w_cnt_next;
    logic          w_take;
    logic [3:0]    w_head_sel;
    logic          w_stop;
    logic          w_dir_onehot;
    logic [3:0]    w_pending_next;

    // Screen-space geometry, widened and signed so edge arithmetic never wraps
    assign w_cx = $signed({3'b000, r_pos_x}) + C_HOFF;
    assign w_cy = $signed({3'b000, r_pos_y}) + C_VOFF;
    assign w_hc = $signed({3'b000, hcount});
    assign w_vc = $signed({3'b000, vcount});

    assign w_in_h = (w_hc >= w_cx - C_H) && (w_hc <= w_cx + C_H);
    assign w_in_v = (w_vc >= w_cy - C_H) && (w_vc <= w_cy + C_H);

    assign sprite_fill = w_in_h && w_in_v;

    assign w_probe[B_L] = (w_hc == w_cx - C_PRB) && w_in_v;
    assign w_probe[B_R] = (w_hc == w_cx + C_PRB) && w_in_v;
    assign w_probe[B_U] = (w_vc == w_cy - C_PRB) && w_in_h;
    assign w_probe[B_D] = (w_vc == w_cy + C_PRB) && w_in_h;

    assign w_hit = w_probe & {4{wall_px}};

    // A hit on the frame_start cycle belongs to the frame that is just beginning
    for (genvar gi = 0; gi < 4; gi++) begin : g_acc
        assign w_acc_next[gi] = w_hit[gi] | (r_acc[gi] & ~frame_start);
    end

    assign w_tick     = enable && (r_cnt == C_CNT_LAST);
    assign w_cnt_next = !enable ? r_cnt : (w_tick ? '0 : r_cnt + TW'(1));

    assign w_take       = (r_pending != 4'b0000) && ((r_pending & r_blocked) == 4'b0000);
    assign w_head_sel   = w_take ? r_pending : r_heading;
    assign w_stop       = (w_head_sel & r_blocked) != 4'b0000;
    assign w_dir_onehot = $onehot(dir_req);

    always_comb begin
        w_pending_next = r_pending;
        if (w_tick && w_take) begin
            w_pending_next = 4'b0000;
        end
        if (w_dir_onehot) begin
            w_pending_next = dir_req;
        end
    end

    always_comb begin
        w_nx = $signed({3'b000, r_pos_x});
        w_ny = $signed({3'b000, r_pos_y});
        if (w_head_sel[B_L]) w_nx = w_nx - C_ONE;
        if (w_head_sel[B_R]) w_nx = w_nx + C_ONE;
        if (w_head_sel[B_U]) w_ny = w_ny - C_ONE;
        if (w_head_sel[B_D]) w_ny = w_ny + C_ONE;
        if (w_nx < C_XMIN)      w_nx = C_XMIN;
        else if (w_nx > C_XMAX) w_nx = C_XMAX;
        if (w_ny < C_YMIN)      w_ny = C_YMIN;
        else if (w_ny > C_YMAX) w_ny = C_YMAX;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos_x   <= CW'(X_INI);
            r_pos_y   <= CW'(Y_INI);
            r_heading <= '0;
            r_pending <= '0;
            r_blocked <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_strobe  <= 1'b0;
        end else if (restart) begin
            r_pos_x   <= CW'(X_INI);
            r_pos_y   <= CW'(Y_INI);
            r_heading <= '0;
            r_pending <= '0;
            r_blocked <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_strobe  <= 1'b0;
        end else begin
            r_acc     <= w_acc_next;
            r_pending <= w_pending_next;
            r_cnt     <= w_cnt_next;
            r_strobe  <= w_tick;
            if (frame_start) begin
                r_blocked <= r_acc;
            end
            if (w_tick) begin
                if (w_stop) begin
                    r_heading <= '0;
                end else begin
                    r_heading <= w_head_sel;
                    r_pos_x   <= CW'(w_nx);
                    r_pos_y   <= CW'(w_ny);
                end
            end
        end
    end

    assign pos_x       = r_pos_x;
    assign pos_y       = r_pos_y;
    assign heading     = r_heading;
    assign blocked     = r_blocked;
    assign step_strobe = r_strobe;

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: fill-box vector table, directed movement/wall sequences,
// then randomized traffic checked every cycle against a pixel-rule reference model.
module tb_sprite_mover;

    localparam int P    = 4;
    localparam int HH   = 8;
    localparam int HOFF = 274;
    localparam int VOFF = 58;
    localparam int XI   = 190;
    localparam int YI   = 318;
    localparam int XMIN = 8;
    localparam int XMAX = 380;
    localparam int YMIN = 8;
    localparam int YMAX = 432;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] dir_req = 4'b0000;
    logic [9:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic       frame_start = 1'b0;
    logic       wall_px = 1'b0;
    logic       sprite_fill;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [3:0] heading;
    logic [3:0] blocked;
    logic       step_strobe;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int         m_x, m_y, m_cnt;
    logic [3:0] m_head, m_pend, m_blk, m_acc;
    bit         m_strobe;

    sprite_mover #(.STEP_PERIOD(P)) dut (
        .clk(clk), .reset(reset), .restart(restart), .enable(enable),
        .dir_req(dir_req), .hcount(hcount), .vcount(vcount),
        .frame_start(frame_start), .wall_px(wall_px),
        .sprite_fill(sprite_fill), .pos_x(pos_x), .pos_y(pos_y),
        .heading(heading), .blocked(blocked), .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dh;
        int dv;
        bit fill;
    } fill_vec_t;

    function automatic bit in_box(int x, int y, int hc, int vc);
        return (hc >= x + HOFF - HH) && (hc <= x + HOFF + HH) &&
               (vc >= y + VOFF - HH) && (vc <= y + VOFF + HH);
    endfunction

    function automatic logic [3:0] probe_hits(int x, int y, int hc, int vc);
        int cx = x + HOFF;
        int cy = y + VOFF;
        bit span_h = (hc >= cx - HH) && (hc <= cx + HH);
        bit span_v = (vc >= cy - HH) && (vc <= cy + HH);
        logic [3:0] r;
        r[3] = (hc == cx - HH - 2) && span_v;
        r[1] = (hc == cx + HH + 2) && span_v;
        r[2] = (vc == cy - HH - 2) && span_h;
        r[0] = (vc == cy + HH + 2) && span_h;
        return r;
    endfunction

    task automatic model_reset();
        m_x = XI; m_y = YI; m_cnt = 0;
        m_head = 0; m_pend = 0; m_blk = 0; m_acc = 0; m_strobe = 0;
    endtask

    task automatic model_edge();
        logic [3:0] hit;
        logic [3:0] want;
        bit tick;
        bit taken;
        hit = wall_px ? probe_hits(m_x, m_y, int'(hcount), int'(vcount)) : 4'b0000;
        if (restart) begin
            model_reset();
            return;
        end
        tick = enable && (m_cnt == P - 1);
        if (enable) m_cnt = tick ? 0 : m_cnt + 1;
        taken = 0;
        if (tick) begin
            want = m_head;
            if (m_pend != 0 && (m_pend & m_blk) == 0) begin
                want = m_pend;
                taken = 1;
            end
            if ((want & m_blk) != 0) begin
                m_head = 0;
            end else begin
                m_head = want;
                case (want)
                    4'b1000: m_x = (m_x - 1 < XMIN) ? XMIN : m_x - 1;
                    4'b0010: m_x = (m_x + 1 > XMAX) ? XMAX : m_x + 1;
                    4'b0100: m_y = (m_y - 1 < YMIN) ? YMIN : m_y - 1;
                    4'b0001: m_y = (m_y + 1 > YMAX) ? YMAX : m_y + 1;
                    default: ;
                endcase
            end
        end
        if (taken) m_pend = 0;
        if ($countones(dir_req) == 1) m_pend = dir_req;
        if (frame_start) begin
            m_blk = m_acc;
            m_acc = hit;
        end else begin
            m_acc = m_acc | hit;
        end
        m_strobe = tick;
    endtask

    task automatic check_vec();
        bit exp_fill;
        exp_fill = in_box(m_x, m_y, int'(hcount), int'(vcount));
        vectors++;
        if (int'(pos_x) != m_x || int'(pos_y) != m_y || heading != m_head ||
            blocked != m_blk || step_strobe != m_strobe || sprite_fill != exp_fill) begin
            miscompares++;
            $display("FAIL model t=%0t pos=(%0d,%0d) want (%0d,%0d) head=%b want %b blk=%b want %b stb=%b want %b fill=%b want %b",
                     $time, pos_x, pos_y, m_x, m_y, heading, m_head, blocked, m_blk,
                     step_strobe, m_strobe, sprite_fill, exp_fill);
        end
    endtask

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_vec();
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            step();
            n++;
        end while (!m_strobe && n < 2 * P);
        if (!m_strobe) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_tick: no tick within %0d cycles", n);
        end
    endtask

    task automatic idle_inputs();
        dir_req = 0; wall_px = 0; frame_start = 0; hcount = 0; vcount = 0;
    endtask

    fill_vec_t fill_tab[10];

    initial begin
        int guard;
        fill_tab[0] = '{0, 0, 1'b1};
        fill_tab[1] = '{8, 0, 1'b1};
        fill_tab[2] = '{9, 0, 1'b0};
        fill_tab[3] = '{-8, -8, 1'b1};
        fill_tab[4] = '{-9, 0, 1'b0};
        fill_tab[5] = '{0, 8, 1'b1};
        fill_tab[6] = '{0, 9, 1'b0};
        fill_tab[7] = '{0, -9, 1'b0};
        fill_tab[8] = '{8, -8, 1'b1};
        fill_tab[9] = '{-10, 10, 1'b0};

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset pos_x", int'(pos_x), 190);
        chk("reset pos_y", int'(pos_y), 318);
        chk("reset heading", int'(heading), 0);
        chk("reset blocked", int'(blocked), 0);
        chk("reset strobe", int'(step_strobe), 0);
        reset = 0;

        // Fill box around centre (464,376) at the reset position
        foreach (fill_tab[i]) begin
            hcount = 10'(464 + fill_tab[i].dh);
            vcount = 10'(376 + fill_tab[i].dv);
            step();
            chk($sformatf("fill[%0d]", i), int'(sprite_fill), int'(fill_tab[i].fill));
        end
        idle_inputs();

        // Move right, one pixel per 4 cycles
        enable = 1;
        dir_req = 4'b0010;
        step();
        dir_req = 0;
        step(); step();
        chk("no tick before period", int'(step_strobe), 0);
        step();
        chk("tick1 strobe", int'(step_strobe), 1);
        chk("tick1 pos_x", int'(pos_x), 191);
        chk("tick1 heading", int'(heading), 4'b0010);
        repeat (4) step();
        chk("tick2 strobe", int'(step_strobe), 1);
        chk("tick2 pos_x", int'(pos_x), 192);

        // Wall on right probe column, then frame_start -> blocked R -> stop
        hcount = 10'(192 + HOFF + HH + 2);
        vcount = 10'(318 + VOFF);
        wall_px = 1;
        step();
        idle_inputs();
        frame_start = 1;
        step();
        frame_start = 0;
        chk("blocked R", int'(blocked), 4'b0010);
        step(); step();
        chk("blocked tick strobe", int'(step_strobe), 1);
        chk("blocked stop heading", int'(heading), 0);
        chk("blocked pos_x hold", int'(pos_x), 192);

        // Unblock, head right again
        frame_start = 1;
        dir_req = 4'b0010;
        step();
        idle_inputs();
        step(); step(); step();
        chk("resume heading", int'(heading), 4'b0010);
        chk("resume pos_x", int'(pos_x), 193);

        // Up requested while up is blocked: pending waits
        hcount = 10'(193 + HOFF);
        vcount = 10'(318 + VOFF - HH - 2);
        wall_px = 1;
        step();
        idle_inputs();
        frame_start = 1;
        dir_req = 4'b0100;
        step();
        idle_inputs();
        chk("blocked U", int'(blocked), 4'b0100);
        step(); step();
        chk("U pend heading stays R", int'(heading), 4'b0010);
        chk("U pend pos_x", int'(pos_x), 194);
        frame_start = 1;
        step();
        frame_start = 0;
        step(); step(); step();
        chk("U taken heading", int'(heading), 4'b0100);
        chk("U taken pos_y", int'(pos_y), 317);
        chk("U taken pos_x", int'(pos_x), 194);

        // Saturate at X_MAX then X_MIN
        dir_req = 4'b0010;
        step();
        dir_req = 0;
        guard = 0;
        while (m_x != XMAX && guard < 1200) begin step(); guard++; end
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            chk("sat X_MAX", int'(pos_x), 380);
        end
        dir_req = 4'b1000;
        step();
        dir_req = 0;
        guard = 0;
        while (m_x != XMIN && guard < 2000) begin step(); guard++; end
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            chk("sat X_MIN", int'(pos_x), 8);
        end
        chk("sat heading L", int'(heading), 4'b1000);

        // Multi-hot request ignored
        dir_req = 4'b1010;
        step();
        dir_req = 0;
        wait_tick();
        chk("multi-hot ignored", int'(heading), 4'b1000);

        // Enable low freezes the counter
        step(); step();
        enable = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("disabled no strobe", int'(step_strobe), 0);
        end
        enable = 1;
        step();
        chk("resume cnt3 no strobe", int'(step_strobe), 0);
        step();
        chk("resume tick", int'(step_strobe), 1);

        // Reset mid-count discards progress
        step(); step();
        reset = 1;
        #1;
        model_reset();
        chk("async reset pos_x", int'(pos_x), 190);
        reset = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("post-reset tick timing", int'(step_strobe), (k == 4) ? 1 : 0);
        end

        // Restart on a tick cycle wins over movement
        dir_req = 4'b0010;
        step();
        dir_req = 0;
        step(); step();
        restart = 1;
        step();
        restart = 0;
        chk("restart pos_x", int'(pos_x), 190);
        chk("restart pos_y", int'(pos_y), 318);
        chk("restart heading", int'(heading), 0);
        chk("restart strobe", int'(step_strobe), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            enable      = ($urandom_range(0, 7) != 0);
            dir_req     = 4'($urandom_range(0, 15));
            frame_start = ($urandom_range(0, 15) == 0);
            wall_px     = ($urandom_range(0, 3) == 0);
            restart     = ($urandom_range(0, 299) == 0);
            hcount      = 10'(m_x + HOFF + int'($urandom_range(0, 26)) - 13);
            vcount      = 10'(m_y + VOFF + int'($urandom_range(0, 26)) - 13);
            step();
        end
        restart = 0;
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
